key_debounce_pulse: RTL and testbench
=====================================

Name: key_debounce_pulse

Overview:
- Upstream stage of the LED GUI path: converts raw, bouncing, active-low push-button inputs into clean single-cycle press pulses.
- Its key_out bus drives the config_sig input of the LED GUI interface, one pulse per confirmed press.
- Each key is synchronised, debounced by a per-key stability counter and FSM, and edge-detected independently.
- A debounced level bus is also exported for hold-style use.

Parameters:
- KEY_NUM, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clock samples required to accept a level change (20 ms at 50 MHz). Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-key counter (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  KEY_NUM  raw button levels; 0 = pressed; asynchronous to clk.
- key_out  output  KEY_NUM  one-clock press pulse per confirmed press (1 = event).
- key_level  output  KEY_NUM  debounced level; 1 = key held.

Behaviour:
- Reset is asynchronous assert and synchronous release (handled at system level). Reset values:
  - key_out = 0, key_level = 0.
  - Both synchroniser stages = all 1s (released).
  - All counters = 0, all FSMs in IDLE.
- Synchroniser: 2-flop chain per bit (s1, then s2). The FSM uses only s2.
- Per-key FSM, four states:
  - IDLE: stable released. If s2=0, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - If s2=1, return to IDLE with cnt=0 (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, pulse key_out=1 for this key next cycle, set key_level=1.
    - Else cnt+1.
  - PRESSED: stable held; key_level=1. If s2=1, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - If s2=0, return to PRESSED with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE with key_level=0 and no pulse.
    - Else cnt+1.
- Latency: let edge 0 be the clock edge where s1 first captures 0.
  - s2 reads 0 from edge 1, so the FSM samples it at edges 2 .. DEBOUNCE_CYCLES+1.
  - key_out is registered high after edge DEBOUNCE_CYCLES+1 and low after edge DEBOUNCE_CYCLES+2. It is exactly one cycle wide.
- key_level follows the same timing for both press and release acceptance.
- Holding a key never repeats the pulse; exactly one pulse per press/release cycle.
- Bounce shorter than DEBOUNCE_CYCLES samples in either direction is fully rejected, and the counter restarts from the new level.
- Channels are fully independent. Simultaneous presses on several keys produce pulses in the same cycle when their acceptance edges coincide. key_out is a bit-vector, not encoded.
- Counter cannot overflow: it saturates by state exit at DEBOUNCE_CYCLES-1, and the CNT_W width covers that value.
- Reset mid-operation: any partial count and any pending or active pulse is discarded immediately, and key_out drops asynchronously.
  - A key still held when reset releases is treated as a new press: after the synchroniser refill plus DEBOUNCE_CYCLES samples, one pulse is produced.
- No combinational path from key_in to any output. All outputs are registered.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=16. Drive key_in=4'b1110 and hold 100 cycles. Expect key_out=4'b0001 for exactly one cycle at edge 17 after s1 captures 0; key_level[0]=1 from the same edge; no further pulses.
- Bounce rejection: key_in[1] toggles low 10 cycles, high 3, low 12, high 2, then low steady. Expect no pulse during bouncing; exactly one pulse 17 edges after the final low capture.
- Release debounce: after an accepted press on key 2, release with 5-cycle glitches back to low. Expect key_level[2] stays 1 until 16 consecutive high samples, then 0; key_out[2] stays 0 throughout.
- Simultaneous keys: key_in goes from 4'b1111 to 4'b0000 in one cycle and is held. Expect key_out=4'b1111 for one cycle, key_level=4'b1111. Then stagger releases and confirm independence.
- Reset mid-count: press key 3, assert rst_n=0 at count 8 for 3 cycles, key still held. Expect outputs 0 during reset; after release, one pulse 17 edges after s1 recapture, and no early pulse.
- Long hold / repeat: 10 press/release cycles of 40 cycles each on key 0. Expect exactly 10 key_out[0] pulses and no other bits active.

Source files
------------

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: per-key 2-flop synchroniser, stability-counter FSM,
// and a single-cycle press pulse plus a debounced held level.
module key_debounce_pulse #(
   parameter int KEY_NUM         = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [KEY_NUM-1:0] key_out,
   output logic [KEY_NUM-1:0] key_level
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   // A wait state exits on the sample that makes the count reach DEBOUNCE_CYCLES.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [KEY_NUM-1:0] sync1_reg;
   logic [KEY_NUM-1:0] sync2_reg;

   // The synchroniser resets to "released" so that a key held through reset
   // is seen as a fresh press once reset lifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '1;
         sync2_reg <= '1;
      end else begin
         sync1_reg <= key_in;
         sync2_reg <= sync1_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
         state_t           state_reg, state_next;
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic             pulse_reg, pulse_next;
         logic             level_reg, level_next;
         logic             key_s;

         assign key_s = sync2_reg[gi];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               pulse_reg <= 1'b0;
               level_reg <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               pulse_reg <= pulse_next;
               level_reg <= level_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            pulse_next = 1'b0;
            level_next = level_reg;
            case (state_reg)
               IDLE: begin
                  if (!key_s) begin
                     state_next = PRESS_WAIT;
                     cnt_next   = CNT_W'(1);
                  end
               end
               PRESS_WAIT: begin
                  if (key_s) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_MAX) begin
                     state_next = PRESSED;
                     cnt_next   = '0;
                     pulse_next = 1'b1;
                     level_next = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
               PRESSED: begin
                  if (key_s) begin
                     state_next = RELEASE_WAIT;
                     cnt_next   = CNT_W'(1);
                  end
               end
               RELEASE_WAIT: begin
                  // Release acceptance clears the level but never pulses.
                  if (!key_s) begin
                     state_next = PRESSED;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_MAX) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                     level_next = 1'b0;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  level_next = 1'b0;
               end
            endcase
         end

         assign key_out[gi]   = pulse_reg;
         assign key_level[gi] = level_reg;
      end
   endgenerate

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEBOUNCE_CYCLES=16: a vector
// table for press/release timing plus hand sequences for bounce and reset.
module tb_key_debounce_pulse;

   localparam int KN = 4;
   localparam int DB = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [KN-1:0] key_in;
   logic [KN-1:0] key_out;
   logic [KN-1:0] key_level;

   int n_cmp = 0;
   int n_err = 0;
   int pulse_cnt [KN];
   int base [KN];

   key_debounce_pulse #(
      .KEY_NUM(KN),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_in(key_in),
      .key_out(key_out),
      .key_level(key_level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < KN; i++)
         if (key_out[i] === 1'b1) pulse_cnt[i] = pulse_cnt[i] + 1;
   end

   typedef struct {
      logic [KN-1:0] key;
      int            ncyc;
      logic [KN-1:0] exp_out;
      logic [KN-1:0] exp_lvl;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("  ok   %s = %0h", name, act);
      end
   endtask

   // Advance n falling edges, then settle so counters and outputs are stable.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [KN-1:0] v, input int n);
      key_in = v;
      tick(n);
   endtask

   task automatic snap_base();
      for (int i = 0; i < KN; i++) base[i] = pulse_cnt[i];
   endtask

   task automatic check_delta(input string name, input int k, input int exp);
      check(name, 32'(pulse_cnt[k] - base[k]), 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < KN; i++) pulse_cnt[i] = 0;
      // Counts are posedges since key_in was driven; edge 0 is the first of them.
      vecs[0]  = '{4'b1110, 17, 4'b0000, 4'b0000};
      vecs[1]  = '{4'b1110,  1, 4'b0001, 4'b0001};
      vecs[2]  = '{4'b1110,  1, 4'b0000, 4'b0001};
      vecs[3]  = '{4'b1110, 50, 4'b0000, 4'b0001};
      vecs[4]  = '{4'b1111, 17, 4'b0000, 4'b0001};
      vecs[5]  = '{4'b1111,  1, 4'b0000, 4'b0000};
      vecs[6]  = '{4'b0000, 17, 4'b0000, 4'b0000};
      vecs[7]  = '{4'b0000,  1, 4'b1111, 4'b1111};
      vecs[8]  = '{4'b0000,  1, 4'b0000, 4'b1111};
      vecs[9]  = '{4'b0001, 10, 4'b0000, 4'b1111};
      vecs[10] = '{4'b0101,  8, 4'b0000, 4'b1110};
      vecs[11] = '{4'b0101, 10, 4'b0000, 4'b1010};
      vecs[12] = '{4'b1111, 18, 4'b0000, 4'b0000};

      rst_n  = 1'b0;
      key_in = '1;
      tick(3);
      check("reset key_out", 32'(key_out), 32'h0);
      check("reset key_level", 32'(key_level), 32'h0);
      rst_n = 1'b1;
      tick(3);

      // Clean press, simultaneous press and staggered releases.
      snap_base();
      for (int v = 0; v < 13; v++) begin
         drive(vecs[v].key, vecs[v].ncyc);
         check($sformatf("vec%0d key_out", v), 32'(key_out), 32'(vecs[v].exp_out));
         check($sformatf("vec%0d key_level", v), 32'(key_level), 32'(vecs[v].exp_lvl));
      end
      check_delta("table pulses k0", 0, 2);
      check_delta("table pulses k1", 1, 1);
      check_delta("table pulses k3", 3, 1);

      // Bounce on key 1, then a steady low.
      snap_base();
      drive(4'b1101, 10);
      drive(4'b1111, 3);
      drive(4'b1101, 12);
      drive(4'b1111, 2);
      drive(4'b1101, 17);
      check("bounce no early pulse", 32'(key_out), 32'h0);
      check_delta("bounce pulses before accept", 1, 0);
      tick(1);
      check("bounce accept key_out", 32'(key_out), 32'h2);
      check("bounce accept key_level", 32'(key_level), 32'h2);
      tick(1);
      check("bounce pulse width", 32'(key_out), 32'h0);
      drive(4'b1111, 20);
      check("bounce release level", 32'(key_level), 32'h0);
      check_delta("bounce total pulses", 1, 1);

      // Release debounce on key 2 with short re-press glitches.
      snap_base();
      drive(4'b1011, 20);
      check("rel press level", 32'(key_level), 32'h4);
      drive(4'b1111, 10);
      check("rel glitch1 level", 32'(key_level), 32'h4);
      drive(4'b1011, 5);
      check("rel low1 level", 32'(key_level), 32'h4);
      drive(4'b1111, 10);
      check("rel glitch2 level", 32'(key_level), 32'h4);
      drive(4'b1011, 5);
      drive(4'b1111, 17);
      check("rel before accept", 32'(key_level), 32'h4);
      tick(1);
      check("rel accepted", 32'(key_level), 32'h0);
      check_delta("rel pulses k2", 2, 1);

      // Reset during a press count on key 3, key held across reset.
      snap_base();
      drive(4'b0111, 9);
      rst_n = 1'b0;
      #1;
      check("midrst key_out", 32'(key_out), 32'h0);
      check("midrst key_level", 32'(key_level), 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(17);
      check("postrst no early pulse", 32'(key_out), 32'h0);
      check_delta("postrst pulses before accept", 3, 0);
      tick(1);
      check("postrst pulse", 32'(key_out), 32'h8);
      check("postrst level", 32'(key_level), 32'h8);
      rst_n = 1'b0;
      #1;
      check("async drop key_out", 32'(key_out), 32'h0);
      check("async drop key_level", 32'(key_level), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(17);
      check("rerst no early pulse", 32'(key_out), 32'h0);
      tick(1);
      check("rerst pulse", 32'(key_out), 32'h8);
      tick(1);
      check("rerst pulse width", 32'(key_out), 32'h0);
      drive(4'b1111, 20);
      check("rst release level", 32'(key_level), 32'h0);
      check_delta("rst pulses k3", 3, 2);

      // Ten press/release cycles on key 0.
      snap_base();
      for (int r = 0; r < 10; r++) begin
         drive(4'b1110, 40);
         check($sformatf("repeat%0d held level", r), 32'(key_level), 32'h1);
         drive(4'b1111, 40);
      end
      check_delta("repeat pulses k0", 0, 10);
      check_delta("repeat pulses k1", 1, 0);
      check_delta("repeat pulses k2", 2, 0);
      check_delta("repeat pulses k3", 3, 0);
      check("repeat final level", 32'(key_level), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
